// File: rtl/aucohl_pkg.sv
// Shared constants and helpers for the aucohl FIFO family: DEPTH derivation
// and the level-count width that bus wrappers use to size threshold registers.
package aucohl_pkg;

  localparam int AUCOHL_AW_DEF = 4;
  localparam int AUCOHL_LVL_W  = AUCOHL_AW_DEF + 1;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  function automatic int lvl_w(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/aucohl_fifo_mem.sv
// FIFO storage: DW x DEPTH register array, synchronous write, asynchronous read
// so the head entry can fall through to the output without a read cycle.
module aucohl_fifo_mem
  import aucohl_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam int DEPTH = depth_of(AW);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/aucohl_fifo_th.sv
// Synchronous FWFT FIFO with 0..DEPTH level count, programmable threshold flag
// and flush. Sticky overflow/underflow flags exist only when AUCOHL_FIFO_ERR_EN is defined.
module aucohl_fifo_th
  import aucohl_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          rd,
  output logic [DW-1:0] rdata,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  input  logic [AW:0]   thr,
  output logic          thr_hit,
  input  logic          err_clr,
  output logic          ovf,
  output logic          udf
);

  localparam int            DEPTH    = depth_of(AW);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_mem_we;

  assign w_full   = (r_level == LVL_FULL);
  assign w_empty  = (r_level == '0);
  // When full, a simultaneous pop frees the head slot, which the push reuses.
  assign w_push   = wr & (~w_full | rd);
  assign w_pop    = rd & ~w_empty;
  assign w_mem_we = w_push & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      if (w_push && !w_pop)      r_level <= r_level + LVL_ONE;
      else if (!w_push && w_pop) r_level <= r_level - LVL_ONE;
    end
  end

  aucohl_fifo_mem #(
    .DW (DW),
    .AW (AW)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_wptr),
    .i_wdata (wdata),
    .i_raddr (r_rptr),
    .o_rdata (rdata)
  );

  assign empty   = w_empty;
  assign full    = w_full;
  assign level   = r_level;
  assign thr_hit = (thr != '0) && (r_level >= thr);

`ifdef AUCOHL_FIFO_ERR_EN
  logic r_ovf;
  logic r_udf;

  // A set event on the same edge as err_clr takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (wr && w_full && !rd && !flush) r_ovf <= 1'b1;
      else if (err_clr)                  r_ovf <= 1'b0;
      if (rd && w_empty && !flush)       r_udf <= 1'b1;
      else if (err_clr)                  r_udf <= 1'b0;
    end
  end

  assign ovf = r_ovf;
  assign udf = r_udf;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_aucohl_fifo_th.sv
// Table-driven bench for aucohl_fifo_th (DW=8, AW=2), plus hand-written
// sequences for reset state and asynchronous reset mid-burst.
module tb_aucohl_fifo_th;

`ifdef AUCOHL_FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       wr;
  logic [7:0] wdata;
  logic       rd;
  logic [7:0] rdata;
  logic       empty;
  logic       full;
  logic [2:0] level;
  logic [2:0] thr;
  logic       thr_hit;
  logic       err_clr;
  logic       ovf;
  logic       udf;

  aucohl_fifo_th #(.DW(8), .AW(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr      (wr),
    .wdata   (wdata),
    .rd      (rd),
    .rdata   (rdata),
    .empty   (empty),
    .full    (full),
    .level   (level),
    .thr     (thr),
    .thr_hit (thr_hit),
    .err_clr (err_clr),
    .ovf     (ovf),
    .udf     (udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic       fl;
    logic       ec;
    logic [2:0] thr;
    logic [2:0] lvl;
    logic       emp;
    logic       ful;
    logic       chk_rd;
    logic [7:0] rdat;
    logic       hit;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add(input logic w, input logic [7:0] wd, input logic r,
                     input logic fl, input logic ec, input logic [2:0] th,
                     input logic [2:0] lv, input logic cr, input logic [7:0] rdat,
                     input logic hit, input logic eo, input logic eu);
    vec_t v;
    v.wr = w; v.wd = wd; v.rd = r; v.fl = fl; v.ec = ec; v.thr = th;
    v.lvl = lv; v.emp = (lv == 3'd0); v.ful = (lv == 3'd4);
    v.chk_rd = cr; v.rdat = rdat; v.hit = hit;
    v.ovf = eo & ERR; v.udf = eu & ERR;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " level"}, 32'(level), 32'(v.lvl));
    chk({tag, " empty"}, 32'(empty), 32'(v.emp));
    chk({tag, " full"}, 32'(full), 32'(v.ful));
    chk({tag, " thr_hit"}, 32'(thr_hit), 32'(v.hit));
    chk({tag, " ovf"}, 32'(ovf), 32'(v.ovf));
    chk({tag, " udf"}, 32'(udf), 32'(v.udf));
    if (v.chk_rd) chk({tag, " rdata"}, 32'(rdata), 32'(v.rdat));
  endtask

  initial begin
    vec_t v;
    //   wr wd     rd fl ec thr  lvl chk rdat   hit ovf udf
    add(1, 8'h11, 0, 0, 0, 3'd0, 3'd1, 1, 8'h11, 0, 0, 0);
    add(1, 8'h22, 0, 0, 0, 3'd0, 3'd2, 1, 8'h11, 0, 0, 0);
    add(1, 8'h33, 0, 0, 0, 3'd0, 3'd3, 1, 8'h11, 0, 0, 0);
    add(1, 8'h44, 0, 0, 0, 3'd0, 3'd4, 1, 8'h11, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 3'd0, 3'd3, 1, 8'h22, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 3'd0, 3'd2, 1, 8'h33, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 3'd0, 3'd1, 1, 8'h44, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 3'd0, 3'd0, 0, 8'h00, 0, 0, 0);
    add(1, 8'h11, 0, 0, 0, 3'd0, 3'd1, 1, 8'h11, 0, 0, 0);
    add(1, 8'h22, 0, 0, 0, 3'd0, 3'd2, 1, 8'h11, 0, 0, 0);
    add(1, 8'h33, 0, 0, 0, 3'd0, 3'd3, 1, 8'h11, 0, 0, 0);
    add(1, 8'h44, 0, 0, 0, 3'd0, 3'd4, 1, 8'h11, 0, 0, 0);
    // simultaneous push/pop while full
    add(1, 8'h55, 1, 0, 0, 3'd0, 3'd4, 1, 8'h22, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 3'd0, 3'd3, 1, 8'h33, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 3'd0, 3'd2, 1, 8'h44, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 3'd0, 3'd1, 1, 8'h55, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 3'd0, 3'd0, 0, 8'h00, 0, 0, 0);
    // simultaneous push/pop while empty
    add(1, 8'hA5, 1, 0, 0, 3'd0, 3'd1, 1, 8'hA5, 0, 0, 1);
    add(0, 8'h00, 0, 0, 1, 3'd0, 3'd1, 1, 8'hA5, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 3'd0, 3'd0, 0, 8'h00, 0, 0, 0);
    // threshold
    add(1, 8'h01, 0, 0, 0, 3'd3, 3'd1, 1, 8'h01, 0, 0, 0);
    add(1, 8'h02, 0, 0, 0, 3'd3, 3'd2, 1, 8'h01, 0, 0, 0);
    add(1, 8'h03, 0, 0, 0, 3'd3, 3'd3, 1, 8'h01, 1, 0, 0);
    add(0, 8'h00, 1, 0, 0, 3'd3, 3'd2, 1, 8'h02, 0, 0, 0);
    add(1, 8'h04, 0, 0, 0, 3'd3, 3'd3, 1, 8'h02, 1, 0, 0);
    add(0, 8'h00, 0, 0, 0, 3'd0, 3'd3, 1, 8'h02, 0, 0, 0);
    add(1, 8'h05, 0, 0, 0, 3'd0, 3'd4, 1, 8'h02, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 3'd5, 3'd4, 1, 8'h02, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 3'd4, 3'd4, 1, 8'h02, 1, 0, 0);
    // overflow, clear, clear coincident with new overflow
    add(1, 8'h66, 0, 0, 0, 3'd0, 3'd4, 1, 8'h02, 0, 1, 0);
    add(0, 8'h00, 0, 0, 1, 3'd0, 3'd4, 1, 8'h02, 0, 0, 0);
    add(1, 8'h77, 0, 0, 1, 3'd0, 3'd4, 1, 8'h02, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 3'd0, 3'd3, 1, 8'h03, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 3'd0, 3'd2, 1, 8'h04, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 3'd0, 3'd1, 1, 8'h05, 0, 1, 0);
    add(0, 8'h00, 1, 0, 0, 3'd0, 3'd0, 0, 8'h00, 0, 1, 0);
    add(0, 8'h00, 0, 0, 1, 3'd0, 3'd0, 0, 8'h00, 0, 0, 0);
    // flush with concurrent push/pop, sticky flags survive flush
    add(1, 8'h81, 0, 0, 0, 3'd0, 3'd1, 1, 8'h81, 0, 0, 0);
    add(1, 8'h82, 0, 0, 0, 3'd0, 3'd2, 1, 8'h81, 0, 0, 0);
    add(1, 8'h83, 0, 0, 0, 3'd0, 3'd3, 1, 8'h81, 0, 0, 0);
    add(1, 8'h99, 1, 1, 0, 3'd0, 3'd0, 0, 8'h00, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 3'd0, 3'd0, 0, 8'h00, 0, 0, 1);
    add(0, 8'h00, 0, 1, 0, 3'd0, 3'd0, 0, 8'h00, 0, 0, 1);
    add(1, 8'h12, 0, 0, 0, 3'd0, 3'd1, 1, 8'h12, 0, 0, 1);
    add(0, 8'h00, 1, 0, 0, 3'd0, 3'd0, 0, 8'h00, 0, 0, 1);

    rst = 1'b1; flush = 1'b0; wr = 1'b0; wdata = '0; rd = 1'b0;
    thr = '0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset level", 32'(level), 32'd0);
    chk("reset empty", 32'(empty), 32'd1);
    chk("reset full", 32'(full), 32'd0);
    chk("reset thr_hit", 32'(thr_hit), 32'd0);
    chk("reset ovf", 32'(ovf), 32'd0);
    chk("reset udf", 32'(udf), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      wr = vq[i].wr; wdata = vq[i].wd; rd = vq[i].rd; flush = vq[i].fl;
      err_clr = vq[i].ec; thr = vq[i].thr;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vq[i]);
    end

    // Asynchronous reset in the middle of a push burst (udf is set here in ERR build)
    @(negedge clk);
    wr = 1'b1; wdata = 8'hC1; rd = 1'b0; flush = 1'b0; err_clr = 1'b0; thr = 3'd1;
    @(negedge clk);
    wdata = 8'hC2;
    @(posedge clk);
    #1;
    v = '{wr:0, wd:0, rd:0, fl:0, ec:0, thr:0, lvl:3'd2, emp:0, ful:0,
          chk_rd:1, rdat:8'hC1, hit:1, ovf:0, udf:ERR};
    chk_all("burst", v);
    #1;
    rst = 1'b1; wr = 1'b0;
    #1;
    chk("async rst level", 32'(level), 32'd0);
    chk("async rst empty", 32'(empty), 32'd1);
    chk("async rst full", 32'(full), 32'd0);
    chk("async rst thr_hit", 32'(thr_hit), 32'd0);
    chk("async rst ovf", 32'(ovf), 32'd0);
    chk("async rst udf", 32'(udf), 32'd0);
    @(negedge clk);
    rst = 1'b0; wr = 1'b1; wdata = 8'hD7;
    @(posedge clk);
    #1;
    v = '{wr:0, wd:0, rd:0, fl:0, ec:0, thr:0, lvl:3'd1, emp:0, ful:0,
          chk_rd:1, rdat:8'hD7, hit:1, ovf:0, udf:0};
    chk_all("post rst", v);
    @(negedge clk);
    wr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aucohl_fifo_th.md
# aucohl_fifo_th

Parametrised synchronous FIFO: successor to the basic library FIFO, for peripheral RX/TX buffering behind bus wrappers. Adds a full-range level count (0..DEPTH), a runtime-programmable threshold flag for interrupt generation, and synchronous flush. Under/overflow detection is optional. Read data is first-word-fall-through: the head entry is visible on `rdata` whenever `empty` is low.

## Interface
- `DW`, 8, data width in bits (≥1)
- `AW`, 4, address width; DEPTH = 2**AW (AW ≥ 1)

- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `flush`  in  1  synchronous clear of contents
- `wr`  in  1  push request
- `wdata`  in  DW  push data
- `rd`  in  1  pop request
- `rdata`  out  DW  head entry (FWFT)
- `empty`  out  1  no entries
- `full`  out  1  DEPTH entries
- `level`  out  AW+1  entry count, 0..DEPTH
- `thr`  in  AW+1  threshold, quasi-static
- `thr_hit`  out  1  level ≥ thr, with thr ≠ 0
- `err_clr`  in  1  clears sticky error flags
- `ovf`  out  1  sticky: push attempted while full
- `udf`  out  1  sticky: pop attempted while empty

## Operation
- Effective push `w_en = wr & (~full | rd)`. Effective pop `r_en = rd & ~empty`.
- Precedence: `rst` > `flush` > push/pop.
- `flush`: pointers and level go to 0, `empty` = 1, `full` = 0. Concurrent `wr`/`rd` are ignored. `ovf`/`udf` are not affected.
- Push only: write `wdata` at the write pointer, increment it, level +1.
- Pop only: increment the read pointer, level −1.
- Push and pop together, non-empty (including full): both pointers advance and level is unchanged. When full, the pushed word occupies the slot just freed.
- Push and pop together, empty: only the push occurs (level 0→1); `udf` sets.
- Pointers are AW bits and wrap modulo DEPTH. Level is AW+1 bits, so DEPTH is representable.
- Full and empty are derived from the level register (level == DEPTH, level == 0), not from pointer comparison.
- `thr_hit` is combinational from the level register and `thr`. `thr` = 0 disables it (held 0). `thr` > DEPTH never hits.
- Memory contents are not reset. `rdata` is undefined when `empty` = 1.

## Timing
- Reset values: `empty` = 1, `full` = 0, `level` = 0, `thr_hit` = 0, `ovf` = 0, `udf` = 0. `rdata` is undefined.
- Push at edge n: `empty` falls and `rdata` shows the word after edge n (latency 1).
- Pop at edge n: `rdata` shows the next entry after edge n.
- `level`, `full`, `empty` and `thr_hit` all update on the same edge as the push/pop that changes them.
- No combinational path from `wr`/`rd` to any output.
- `rst` asserted mid-operation clears state immediately and asynchronously. Operation resumes on the first edge after deassertion.

## Configuration
- Macro: `AUCOHL_FIFO_ERR_EN`.
- Defined: `ovf` sets on any edge with `wr & full & ~rd & ~flush`. `udf` sets on any edge with `rd & empty & ~flush`. Both are sticky until `err_clr` or `rst`. If `err_clr` and a set event occur on the same edge, the set wins.
- Undefined: `ovf` and `udf` are tied 0, `err_clr` is ignored, and no flops are inferred. Ports remain present.
- Push/pop behaviour is identical in both builds.

## Structure
- Shared package `aucohl_pkg`: DEPTH derivation helper and the level-width constant (AW+1) used by wrappers sizing `thr` registers.
- One sub-module, `aucohl_fifo_mem`, holds the storage:
  - DW×DEPTH register array
  - synchronous write port
  - asynchronous read port
- Pointers, level, flags and error logic live in the top module.

## Test plan
- Reset, then DW=8/AW=2. Push 0x11,0x22,0x33,0x44 → `full`=1, `level`=4. Pop ×4 → reads 0x11..0x44 in order, `empty`=1, `level`=0.
- Full FIFO, `wr` + `rd` together with 0x55 → `rdata` advances to 0x22, `level` stays 4. Draining then yields 0x22,0x33,0x44,0x55.
- Empty FIFO, `wr` (0xA5) + `rd` together → `level`=1, `rdata`=0xA5. `udf`=1 (ERR_EN build) / 0 (non-ERR_EN build).
- `thr`=3: push 3 → `thr_hit` rises on the 3rd push edge. Pop 1 → falls. Set `thr`=0 → stays 0 at any level.
- Push while full → `ovf`=1 and contents unchanged. `err_clr` pulse → `ovf`=0. `err_clr` coincident with a new overflow → `ovf` stays 1.
- Three entries stored, then `flush` together with `wr` → `level`=0, `empty`=1, and the pushed data is discarded. Assert `rst` mid-burst → all outputs return to reset values without a clock edge.
